// File: rtl/ps2_keypad.sv
// ps2_keypad
// Decodes PS/2 scancode-set-2 bytes into the CHIP-8 hex keypad state.
//
// Parameters
//   TIMEOUT_CYCLES         clk cycles a prefix state (F0/E0) waits for its
//                          next byte before the prefix is abandoned
// Ports
//   clk                    PS/2-domain clock, all state on its rising edge
//   rst                    asynchronous active-low reset
//   byte_data[7:0]         received scancode byte
//   byte_valid             one-cycle strobe, byte_data valid
//   byte_err               one-cycle strobe, receiver dropped a frame
//   clear_newest_key_down  consumes the latched newest key press
//   input_keys[15:0]       held state of CHIP-8 keys, bit n = key n down
//   newest_key_down[4:0]   [4] latched press valid, [3:0] key index
//   any_key                registered OR of input_keys
module ps2_keypad #(
  parameter int TIMEOUT_CYCLES = 1250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  input  logic        byte_err,
  input  logic        clear_newest_key_down,
  output logic [15:0] input_keys,
  output logic [4:0]  newest_key_down,
  output logic        any_key
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_timeoutCnt;
  logic [15:0]    r_keys;
  logic [4:0]     r_newest;
  logic           r_anyKey;
  logic [1:0]     r_rstSync;

  logic           w_rstN;
  logic           w_byteOk;
  logic [4:0]     w_map;
  logic           w_isReset;
  logic [15:0]    w_keysNext;

  // Returns {mapped, chip8_index} for a set-2 make code.
  function automatic logic [4:0] mapCode(input logic [7:0] code);
    case (code)
      8'h16: mapCode = 5'h11;
      8'h1E: mapCode = 5'h12;
      8'h26: mapCode = 5'h13;
      8'h25: mapCode = 5'h1C;
      8'h15: mapCode = 5'h14;
      8'h1D: mapCode = 5'h15;
      8'h24: mapCode = 5'h16;
      8'h2D: mapCode = 5'h1D;
      8'h1C: mapCode = 5'h17;
      8'h1B: mapCode = 5'h18;
      8'h23: mapCode = 5'h19;
      8'h2B: mapCode = 5'h1E;
      8'h1A: mapCode = 5'h1A;
      8'h22: mapCode = 5'h10;
      8'h21: mapCode = 5'h1B;
      8'h2A: mapCode = 5'h1F;
      default: mapCode = 5'h00;
    endcase
  endfunction

  // Reset asserts immediately, releases two edges later in step with clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstSync <= 2'b00;
    end else begin
      r_rstSync <= {r_rstSync[0], 1'b1};
    end
  end

  assign w_rstN    = r_rstSync[1];
  // A frame error discards any byte that arrives with it.
  assign w_byteOk  = byte_valid && !byte_err;
  assign w_map     = mapCode(byte_data);
  // BAT result / failure and resend codes mean the keyboard restarted.
  assign w_isReset = (byte_data == 8'hAA) || (byte_data == 8'hFC) ||
                     (byte_data == 8'hFE);

  // Next key state is computed ahead so any_key can be registered in step.
  always_comb begin
    w_keysNext = r_keys;
    if (w_byteOk) begin
      if (r_state == IDLE) begin
        if (w_isReset) begin
          w_keysNext = 16'h0000;
        end else if (w_map[4]) begin
          w_keysNext[w_map[3:0]] = 1'b1;
        end
      end else if (r_state == BRK && w_map[4]) begin
        w_keysNext[w_map[3:0]] = 1'b0;
      end
    end
  end

  // Decoder FSM, prefix timeout and registered outputs.
  always_ff @(posedge clk or negedge w_rstN) begin
    if (!w_rstN) begin
      r_state      <= IDLE;
      r_timeoutCnt <= '0;
      r_keys       <= 16'h0000;
      r_newest     <= 5'b00000;
      r_anyKey     <= 1'b0;
    end else begin
      r_keys   <= w_keysNext;
      r_anyKey <= |w_keysNext;

      if (clear_newest_key_down) begin
        r_newest[4] <= 1'b0;
      end
      // A new press overrides a simultaneous clear; repeats leave it alone.
      if (w_byteOk && r_state == IDLE) begin
        if (w_isReset) begin
          r_newest[4] <= 1'b0;
        end else if (w_map[4] && !r_keys[w_map[3:0]]) begin
          r_newest <= {1'b1, w_map[3:0]};
        end
      end

      if (byte_err) begin
        r_state      <= IDLE;
        r_timeoutCnt <= '0;
      end else if (byte_valid) begin
        r_timeoutCnt <= '0;
        case (r_state)
          IDLE: begin
            if (byte_data == 8'hF0) begin
              r_state <= BRK;
            end else if (byte_data == 8'hE0) begin
              r_state <= EXT;
            end else begin
              r_state <= IDLE;
            end
          end
          EXT: begin
            r_state <= (byte_data == 8'hF0) ? EXT_BRK : IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state != IDLE) begin
        // Saturates at the limit: reaching it abandons the prefix.
        if (r_timeoutCnt == TIMEOUT_MAX) begin
          r_state      <= IDLE;
          r_timeoutCnt <= '0;
        end else begin
          r_timeoutCnt <= r_timeoutCnt + CNT_ONE;
        end
      end else begin
        r_timeoutCnt <= '0;
      end
    end
  end

  assign input_keys      = r_keys;
  assign newest_key_down = r_newest;
  assign any_key         = r_anyKey;

endmodule

// File: tb/tb_ps2_keypad.sv
// tb_ps2_keypad
// Directed scancode sequences for ps2_keypad. Each stimulus pushes its
// hand-computed expected outputs into a queue; a monitor pops and compares
// one entry after every cycle in which a strobe was presented.
module tb_ps2_keypad;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_err;
  logic        clear_newest_key_down;
  logic [15:0] input_keys;
  logic [4:0]  newest_key_down;
  logic        any_key;

  int errors = 0;
  int checks = 0;
  logic [21:0] expQ[$];

  ps2_keypad #(.TIMEOUT_CYCLES(1250)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .byte_data             (byte_data),
    .byte_valid            (byte_valid),
    .byte_err              (byte_err),
    .clear_newest_key_down (clear_newest_key_down),
    .input_keys            (input_keys),
    .newest_key_down       (newest_key_down),
    .any_key               (any_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its required value.
  task automatic checkOutput(input string name, input logic [21:0] actual,
                             input logic [21:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got keys=%h newest=%h any=%b, expected keys=%h newest=%h any=%b",
               name, actual[21:6], actual[5:1], actual[0],
               required[21:6], required[5:1], required[0]);
    end
  endtask

  // Drives one strobe cycle and queues the outputs expected after it.
  task automatic applyStimulus(input logic [7:0] data, input logic valid,
                               input logic err, input logic clr,
                               input logic [15:0] expKeys,
                               input logic [4:0] expNewest);
    @(negedge clk);
    byte_data             = data;
    byte_valid            = valid;
    byte_err              = err;
    clear_newest_key_down = clr;
    expQ.push_back({expKeys, expNewest, |expKeys});
    @(negedge clk);
    byte_valid            = 1'b0;
    byte_err              = 1'b0;
    clear_newest_key_down = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] data, input logic [15:0] expKeys,
                          input logic [4:0] expNewest);
    applyStimulus(data, 1'b1, 1'b0, 1'b0, expKeys, expNewest);
  endtask

  // Monitor: any strobe seen at an edge means the DUT presents a result.
  initial begin
    logic strobe;
    logic [21:0] exp;
    forever begin
      @(posedge clk);
      strobe = byte_valid | byte_err | clear_newest_key_down;
      @(negedge clk);
      if (strobe) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", {input_keys, newest_key_down, any_key}, 22'h3FFFFF);
        end else begin
          exp = expQ.pop_front();
          checkOutput($sformatf("txn%0d", checks),
                      {input_keys, newest_key_down, any_key}, exp);
        end
      end
    end
  end

  task automatic drainQueue();
    int budget = 20;
    while (expQ.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    rst                   = 1'b0;
    byte_data             = 8'h00;
    byte_valid            = 1'b0;
    byte_err              = 1'b0;
    clear_newest_key_down = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {input_keys, newest_key_down, any_key}, 22'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("post_reset_idle", {input_keys, newest_key_down, any_key}, 22'h0);

    // Press and release key 5.
    sendByte(8'h1D, 16'h0020, 5'h15);
    sendByte(8'hF0, 16'h0020, 5'h15);
    sendByte(8'h1D, 16'h0000, 5'h15);

    // Typematic key A with a consume between repeats.
    sendByte(8'h1A, 16'h0400, 5'h1A);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 16'h0400, 5'h0A);
    sendByte(8'h1A, 16'h0400, 5'h0A);
    sendByte(8'h1A, 16'h0400, 5'h0A);
    sendByte(8'hF0, 16'h0400, 5'h0A);
    sendByte(8'h1A, 16'h0000, 5'h0A);

    // Make of key 0 beats a simultaneous clear.
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b1, 16'h0001, 5'h10);
    sendByte(8'hF0, 16'h0001, 5'h10);
    sendByte(8'h22, 16'h0000, 5'h10);

    // Extended sequences leave keys alone and return to IDLE.
    sendByte(8'h16, 16'h0002, 5'h11);
    sendByte(8'hE0, 16'h0002, 5'h11);
    sendByte(8'hF0, 16'h0002, 5'h11);
    sendByte(8'h16, 16'h0002, 5'h11);
    sendByte(8'hE0, 16'h0002, 5'h11);
    sendByte(8'h75, 16'h0002, 5'h11);
    sendByte(8'h1E, 16'h0006, 5'h12);
    sendByte(8'h5A, 16'h0006, 5'h12);
    sendByte(8'hF0, 16'h0006, 5'h12);
    sendByte(8'h16, 16'h0004, 5'h12);
    sendByte(8'hF0, 16'h0004, 5'h12);
    sendByte(8'h1E, 16'h0000, 5'h12);

    // Abandoned break prefix: next byte is a make.
    sendByte(8'hF0, 16'h0000, 5'h12);
    repeat (1260) @(negedge clk);
    sendByte(8'h25, 16'h1000, 5'h1C);
    sendByte(8'hF0, 16'h1000, 5'h1C);
    sendByte(8'h25, 16'h0000, 5'h1C);

    // Keyboard self-test result clears everything.
    sendByte(8'h15, 16'h0010, 5'h14);
    sendByte(8'h2A, 16'h8010, 5'h1F);
    sendByte(8'hAA, 16'h0000, 5'h0F);

    // Frame error drops the break prefix.
    sendByte(8'hF0, 16'h0000, 5'h0F);
    applyStimulus(8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 5'h0F);
    sendByte(8'h15, 16'h0010, 5'h14);
    applyStimulus(8'h1D, 1'b1, 1'b1, 1'b0, 16'h0010, 5'h14);
    sendByte(8'h1D, 16'h0030, 5'h15);

    // Reset mid-prefix discards it.
    sendByte(8'hF0, 16'h0030, 5'h15);
    drainQueue();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("async_reset", {input_keys, newest_key_down, any_key}, 22'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    sendByte(8'h1C, 16'h0080, 5'h17);

    drainQueue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
